// File: rtl/seq_match_ctrl.sv
// Job-level controller for a programmable, overlapping serial pattern search.
// A start command latches the configuration; the job ends with a done pulse and a found/not-found result.
module seq_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] pat_len_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             seq_valid_i,
  input  logic             seq_in,
  output logic             busy_o,
  output logic             match_o,
  output logic             done_o,
  output logic             found_o,
  output logic             cfg_err_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [WIN_W-1:0] bit_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             found_q, found_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

  logic [PAT_W-1:0] hist_new_s;
  logic [PAT_W-1:0] mask_s;
  logic [WIN_W-1:0] bit_new_s;
  logic             hit_s;
  logic             final_s;
  logic             expire_s;
  logic             cfg_bad_s;

  // Candidate history/count for the bit on the input this cycle, plus length mask and completion decode.
  always_comb begin
    hist_new_s = {hist_q[PAT_W-2:0], seq_in};
    if (bit_cnt_q == {WIN_W{1'b1}}) begin
      bit_new_s = bit_cnt_q;
    end else begin
      bit_new_s = bit_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
    end
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
    // A hit needs at least len accepted bits so stale zeros in the history cannot match.
    hit_s     = (((hist_new_s ^ pat_q) & mask_s) == {PAT_W{1'b0}}) &&
                (bit_new_s >= WIN_W'(len_q));
    final_s   = hit_s && (match_cnt_q == (tgt_q - {{(CNT_W-1){1'b0}}, 1'b1}));
    expire_s  = (win_q != {WIN_W{1'b0}}) && (bit_new_s == win_q);
    cfg_bad_s = (pat_len_i == {LEN_W{1'b0}}) ||
                (pat_len_i > LEN_W'(PAT_W)) ||
                (target_i == {CNT_W{1'b0}});
  end

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    tgt_d       = tgt_q;
    win_d       = win_q;
    hist_d      = hist_q;
    match_cnt_d = match_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    found_d     = found_q;
    match_d     = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_bad_s) begin
            cfg_err_d = 1'b1;
          end else begin
            pat_d       = pattern_i;
            len_d       = pat_len_i;
            tgt_d       = target_i;
            win_d       = window_i;
            hist_d      = {PAT_W{1'b0}};
            match_cnt_d = {CNT_W{1'b0}};
            bit_cnt_d   = {WIN_W{1'b0}};
            found_d     = 1'b0;
            state_d     = ST_SEARCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        // Abort outranks any match or window completion arriving on the same edge.
        if (abort_i) begin
          found_d = 1'b0;
          state_d = ST_IDLE;
        end else if (seq_valid_i) begin
          hist_d    = hist_new_s;
          bit_cnt_d = bit_new_s;
          if (hit_s) begin
            match_cnt_d = match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            match_d     = 1'b1;
          end else begin
            match_cnt_d = match_cnt_q;
          end
          if (final_s) begin
            found_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (expire_s) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort_i) begin
          found_d = 1'b0;
        end else begin
          found_d = found_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration, history, counters and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      pat_q       <= {PAT_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      tgt_q       <= {CNT_W{1'b0}};
      win_q       <= {WIN_W{1'b0}};
      hist_q      <= {PAT_W{1'b0}};
      match_cnt_q <= {CNT_W{1'b0}};
      bit_cnt_q   <= {WIN_W{1'b0}};
      found_q     <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      tgt_q       <= tgt_d;
      win_q       <= win_d;
      hist_q      <= hist_d;
      match_cnt_q <= match_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      found_q     <= found_d;
      match_q     <= match_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign match_o     = match_q;
  assign done_o      = done_q;
  assign found_o     = found_q;
  assign cfg_err_o   = cfg_err_q;
  assign match_cnt_o = match_cnt_q;
  assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: a reference model pushes expected match/done
// per cycle into a scoreboard queue, popped and compared after each clock edge.
module tb_seq_match_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clk;
  logic             reset_ni;
  logic             start_i;
  logic             abort_i;
  logic [PAT_W-1:0] pattern_i;
  logic [LEN_W-1:0] pat_len_i;
  logic [CNT_W-1:0] target_i;
  logic [WIN_W-1:0] window_i;
  logic             seq_valid_i;
  logic             seq_in;
  logic             busy_o;
  logic             match_o;
  logic             done_o;
  logic             found_o;
  logic             cfg_err_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic [WIN_W-1:0] bit_cnt_o;

  seq_match_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .pattern_i   (pattern_i),
    .pat_len_i   (pat_len_i),
    .target_i    (target_i),
    .window_i    (window_i),
    .seq_valid_i (seq_valid_i),
    .seq_in      (seq_in),
    .busy_o      (busy_o),
    .match_o     (match_o),
    .done_o      (done_o),
    .found_o     (found_o),
    .cfg_err_o   (cfg_err_o),
    .match_cnt_o (match_cnt_o),
    .bit_cnt_o   (bit_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic m;
    logic d;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_hist;
  logic [7:0]  m_pat;
  int          m_len, m_tgt, m_win, m_cnt, m_bits;
  bit          m_active;

  task automatic model_step(input logic b, input logic v);
    exp_t e;
    bit   hit;
    e.m = 1'b0;
    e.d = 1'b0;
    if (m_active && v) begin
      m_hist = {m_hist[30:0], b};
      m_bits++;
      hit = (m_bits >= m_len);
      for (int k = 0; k < m_len; k++) begin
        if (m_hist[k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) m_cnt++;
      e.m = hit;
      if (hit && m_cnt == m_tgt) begin
        e.d = 1'b1;
        m_active = 1'b0;
      end else if (m_win != 0 && m_bits == m_win) begin
        e.d = 1'b1;
        m_active = 1'b0;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic start_job(input logic [7:0] pat, input int len, input int tgt, input int win);
    pattern_i = pat;
    pat_len_i = LEN_W'(len);
    target_i  = CNT_W'(tgt);
    window_i  = WIN_W'(win);
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    m_pat    = pat;
    m_len    = len;
    m_tgt    = tgt;
    m_win    = win;
    m_cnt    = 0;
    m_bits   = 0;
    m_hist   = '0;
    m_active = 1'b1;
    sb_q.delete();
    checks++;
    if (busy_o !== 1'b1 || found_o !== 1'b0 || match_cnt_o !== 8'd0 || bit_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL start_accept: busy=%b found=%b cnt=%0d bits=%0d, required 1 0 0 0",
               busy_o, found_o, match_cnt_o, bit_cnt_o);
    end
  endtask

  task automatic feed_seq(input logic [15:0] bits, input logic [15:0] vld, input int n,
                          input string name);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      seq_in      = bits[n-1-i];
      seq_valid_i = vld[n-1-i];
      model_step(seq_in, seq_valid_i);
      @(posedge clk); #1;
      seq_valid_i = 1'b0;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_sb: scoreboard empty at cycle %0d", name, i);
      end else begin
        e = sb_q.pop_front();
        if (match_o !== e.m || done_o !== e.d) begin
          errors++;
          $display("FAIL %s_cycle%0d: match=%b done=%b, required match=%b done=%b",
                   name, i, match_o, done_o, e.m, e.d);
        end
      end
    end
  endtask

  task automatic check_result(input logic fnd, input int cnt, input int nbits, input string name);
    checks++;
    if (found_o !== fnd || match_cnt_o !== CNT_W'(cnt) || bit_cnt_o !== WIN_W'(nbits)) begin
      errors++;
      $display("FAIL %s_result: found=%b cnt=%0d bits=%0d, required found=%b cnt=%0d bits=%0d",
               name, found_o, match_cnt_o, bit_cnt_o, fnd, cnt, nbits);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || match_o !== 1'b0 || found_o !== fnd) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b match=%b found=%b, required 0 0 0 %b",
               name, busy_o, done_o, match_o, found_o, fnd);
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, match_o, done_o, found_o, cfg_err_o, match_cnt_o, bit_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b match=%b done=%b found=%b err=%b cnt=%0d bits=%0d, required all 0",
               busy_o, match_o, done_o, found_o, cfg_err_o, match_cnt_o, bit_cnt_o);
    end
    #3 reset_ni = 1'b1;
  endtask

  task automatic test_basic();
    start_job(8'b110, 3, 2, 0);
    feed_seq(16'b110110, 16'b111111, 6, "basic");
    check_result(1'b1, 2, 6, "basic");
  endtask

  task automatic test_overlap();
    start_job(8'b1010, 4, 2, 0);
    feed_seq(16'b101010, 16'b111111, 6, "overlap");
    check_result(1'b1, 2, 6, "overlap");
  endtask

  task automatic test_window();
    start_job(8'b111, 3, 1, 5);
    feed_seq(16'b11011, 16'b11111, 5, "window");
    check_result(1'b0, 0, 5, "window");
  endtask

  task automatic test_tie_gaps();
    start_job(8'b11, 2, 1, 2);
    feed_seq(16'b101, 16'b101, 3, "tie");
    check_result(1'b1, 1, 2, "tie");
  endtask

  task automatic cfg_reject(input int len, input int tgt, input string name);
    pattern_i = 8'hA5;
    pat_len_i = LEN_W'(len);
    target_i  = CNT_W'(tgt);
    window_i  = 16'd0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_reject: cfg_err=%b busy=%b, required 1 0", name, cfg_err_o, busy_o);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: cfg_err=%b busy=%b, required 0 0", name, cfg_err_o, busy_o);
    end
  endtask

  task automatic test_cfg_abort();
    cfg_reject(0, 1, "len0");
    cfg_reject(9, 1, "len9");
    cfg_reject(3, 0, "tgt0");
    start_job(8'b101, 3, 1, 0);
    feed_seq(16'b10, 16'b11, 2, "abort");
    abort_i = 1'b1;
    seq_in = 1'b1;
    seq_valid_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    seq_valid_i = 1'b0;
    sb_q.delete();
    m_active = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || match_o !== 1'b0 || found_o !== 1'b0 ||
        bit_cnt_o !== 16'd2 || match_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b match=%b found=%b bits=%0d cnt=%0d, required 0 0 0 0 2 0",
               busy_o, done_o, match_o, found_o, bit_cnt_o, match_cnt_o);
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: done=%b busy=%b, required 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_async_reset();
    start_job(8'b110, 3, 2, 0);
    feed_seq(16'b11, 16'b11, 2, "prereset");
    #3 reset_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, match_o, done_o, found_o, cfg_err_o, match_cnt_o, bit_cnt_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b match=%b done=%b found=%b cnt=%0d bits=%0d, required all 0",
               busy_o, match_o, done_o, found_o, match_cnt_o, bit_cnt_o);
    end
    sb_q.delete();
    m_active = 1'b0;
    @(posedge clk);
    #4 reset_ni = 1'b1;
    test_basic();
  endtask

  initial begin
    reset_ni    = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    pattern_i   = '0;
    pat_len_i   = '0;
    target_i    = '0;
    window_i    = '0;
    seq_valid_i = 1'b0;
    seq_in      = 1'b0;
    m_active    = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_window();
    test_tie_gaps();
    test_cfg_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
